// File: rtl/bill_feeder_if.sv
// Bill feeder bus: validator handshake plus ticket-machine status and credit pulses.
interface bill_feeder_if;
  logic       bill_valid;
  logic [1:0] bill_code;
  logic       bill_accept;
  logic       bill_reject;
  logic       ready;
  logic       bill;
  logic       dispense;
  logic       return_sig;
  logic       ten;
  logic       twenty;

  // Environment side: validator and ticket machine.
  modport master (
    output bill_valid, bill_code, ready, bill, dispense, return_sig,
    input  bill_accept, bill_reject, ten, twenty
  );

  // Feeder side.
  modport slave (
    input  bill_valid, bill_code, ready, bill, dispense, return_sig,
    output bill_accept, bill_reject, ten, twenty
  );
endinterface

// File: rtl/bill_feeder.sv
// Bill feeder: queues validated bills in a small FIFO and replays each one as a
// single registered ten/twenty pulse to the ticket machine, spaced three cycles apart.
module bill_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    clear,
  bill_feeder_if.slave            bus,
  output logic [CNT_W-1:0]        ticket_count,
  output logic [CNT_W-1:0]        refund_count,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    busy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPulse, StSettle} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  mem_q, mem_d;        // 0 = ten, 1 = twenty
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              accept_q, accept_d;
  logic              reject_q, reject_d;
  logic              ten_q, ten_d;
  logic              twenty_q, twenty_d;
  logic [CNT_W-1:0]  ticket_q, ticket_d;
  logic [CNT_W-1:0]  refund_q, refund_d;

  logic code_ok;
  logic push;
  logic pop;

  // Pulse sequencer: pop the head bill when the machine can take credit.
  always_comb begin
    state_d  = state_q;
    ten_d    = 1'b0;
    twenty_d = 1'b0;
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        if ((level_q != '0) && (bus.ready || bus.bill) && !bus.dispense && !bus.return_sig) begin
          state_d  = StPulse;
          pop      = 1'b1;
          ten_d    = ~mem_q[rd_ptr_q];
          twenty_d = mem_q[rd_ptr_q];
        end
      end
      StPulse:  state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FIFO write side and accept/reject decision; fullness is judged on the pre-edge level.
  always_comb begin
    code_ok  = (bus.bill_code == 2'b01) || (bus.bill_code == 2'b10);
    push     = bus.bill_valid && code_ok && (level_q != LvlFull);
    accept_d = push;
    reject_d = bus.bill_valid && !push;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = (bus.bill_code == 2'b10);
    end
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    level_d  = level_q + LvlW'(push) - LvlW'(pop);
  end

  // Saturating ticket and refund counters.
  always_comb begin
    ticket_d = ticket_q;
    refund_d = refund_q;
    if (bus.dispense && (ticket_q != '1)) begin
      ticket_d = ticket_q + CNT_W'(1);
    end
    if (bus.return_sig && (refund_q != '1)) begin
      refund_d = refund_q + CNT_W'(1);
    end
  end

  // Control state with synchronous clear taking priority over everything.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      ten_q    <= 1'b0;
      twenty_q <= 1'b0;
      ticket_q <= '0;
      refund_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      ten_q    <= ten_d;
      twenty_q <= twenty_d;
      ticket_q <= ticket_d;
      refund_q <= refund_d;
    end
  end

  // FIFO storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.bill_accept = accept_q;
  assign bus.bill_reject = reject_q;
  assign bus.ten         = ten_q;
  assign bus.twenty      = twenty_q;
  assign ticket_count    = ticket_q;
  assign refund_count    = refund_q;
  assign fifo_level      = level_q;
  assign busy            = (level_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_bill_feeder.sv
// Bench for bill_feeder: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_bill_feeder;

  localparam int Depth  = 4;
  localparam int CntW   = 8;
  localparam int CntMax = 255;

  logic            clk;
  logic            clear;
  logic [CntW-1:0] ticket_count;
  logic [CntW-1:0] refund_count;
  logic [2:0]      fifo_level;
  logic            busy;

  bill_feeder_if bus ();

  bill_feeder #(
    .DEPTH (Depth),
    .CNT_W (CntW)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .bus          (bus),
    .ticket_count (ticket_count),
    .refund_count (refund_count),
    .fifo_level   (fifo_level),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bills as a queue, pulse spacing as elapsed edges since the last pop.
  bit mq[$];
  int cyc      = 0;
  int last_pop = -1000;
  int m_ticket = 0;
  int m_refund = 0;
  bit m_acc    = 1'b0;
  bit m_rej    = 1'b0;
  bit m_ten    = 1'b0;
  bit m_twenty = 1'b0;
  bit m_busy   = 1'b0;

  task automatic model_step();
    bit code_ok, push_ok, pop_now, head;
    cyc++;
    if (clear) begin
      mq.delete();
      last_pop = -1000;
      m_ticket = 0;
      m_refund = 0;
      m_acc    = 1'b0;
      m_rej    = 1'b0;
      m_ten    = 1'b0;
      m_twenty = 1'b0;
    end else begin
      code_ok = (bus.bill_code == 2'b01) || (bus.bill_code == 2'b10);
      push_ok = bus.bill_valid && code_ok && (mq.size() < Depth);
      pop_now = (mq.size() > 0) && (bus.ready || bus.bill) && !bus.dispense &&
                !bus.return_sig && (cyc - last_pop >= 3);
      m_acc = push_ok;
      m_rej = bus.bill_valid && !push_ok;
      m_ten    = 1'b0;
      m_twenty = 1'b0;
      if (pop_now) begin
        head     = mq.pop_front();
        last_pop = cyc;
        m_ten    = !head;
        m_twenty = head;
      end
      if (push_ok) mq.push_back(bus.bill_code == 2'b10);
      if (bus.dispense && m_ticket < CntMax) m_ticket++;
      if (bus.return_sig && m_refund < CntMax) m_refund++;
    end
    m_busy = (mq.size() > 0) || (cyc - last_pop < 2);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Pulse log and handshake counters from observed outputs, for directed checks.
  int pl_type[$];
  int pl_cyc[$];
  int mon_acc = 0;
  int mon_rej = 0;

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("accept", int'(bus.bill_accept), int'(m_acc));
        check("reject", int'(bus.bill_reject), int'(m_rej));
        check("ten", int'(bus.ten), int'(m_ten));
        check("twenty", int'(bus.twenty), int'(m_twenty));
        check("ticket_count", int'(ticket_count), m_ticket);
        check("refund_count", int'(refund_count), m_refund);
        check("fifo_level", int'(fifo_level), mq.size());
        check("busy", int'(busy), int'(m_busy));
        if (bus.ten || bus.twenty) begin
          pl_type.push_back(bus.twenty ? 1 : 0);
          pl_cyc.push_back(cyc);
        end
        if (bus.bill_accept) mon_acc++;
        if (bus.bill_reject) mon_rej++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.bill_valid = 1'b0;
    bus.bill_code  = 2'b00;
    bus.dispense   = 1'b0;
    bus.return_sig = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pl_type.delete();
    pl_cyc.delete();
    mon_acc = 0;
    mon_rej = 0;
  endtask

  task automatic push_bill(input logic [1:0] code);
    bus.bill_valid = 1'b1;
    bus.bill_code  = code;
    tick();
    bus.bill_valid = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    bus.ready = 1'b0;
    bus.bill  = 1'b0;
    idle_inputs();
    tick();
    do_clear();
    chk_en = 1'b1;

    // Reset state.
    check("rst_level", int'(fifo_level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ten", int'(bus.ten), 0);
    check("rst_ticket", int'(ticket_count), 0);

    // Single ten bill into a ready machine.
    bus.ready = 1'b1;
    push_bill(2'b01);
    check("t1_accept", int'(bus.bill_accept), 1);
    check("t1_level1", int'(fifo_level), 1);
    check("t1_ten_early", int'(bus.ten), 0);
    tick();
    check("t1_ten", int'(bus.ten), 1);
    check("t1_level0", int'(fifo_level), 0);
    check("t1_accept_end", int'(bus.bill_accept), 0);
    tick();
    check("t1_ten_low", int'(bus.ten), 0);
    check("t1_busy_settle", int'(busy), 1);
    tick();
    check("t1_busy_idle", int'(busy), 0);

    // Three back-to-back bills: ten, twenty, twenty spaced three cycles apart.
    do_clear();
    bus.ready = 1'b1;
    push_bill(2'b01);
    push_bill(2'b10);
    push_bill(2'b10);
    repeat (10) tick();
    check("t2_npulses", pl_type.size(), 3);
    if (pl_type.size() == 3) begin
      check("t2_type0", pl_type[0], 0);
      check("t2_type1", pl_type[1], 1);
      check("t2_type2", pl_type[2], 1);
      check("t2_gap1", pl_cyc[1] - pl_cyc[0], 3);
      check("t2_gap2", pl_cyc[2] - pl_cyc[1], 3);
    end
    bus.dispense = 1'b1;
    tick();
    bus.dispense = 1'b0;
    check("t2_ticket", int'(ticket_count), 1);

    // Fill to full with the machine idle, then overflow.
    do_clear();
    bus.ready = 1'b0;
    bus.bill  = 1'b0;
    push_bill(2'b01);
    push_bill(2'b10);
    push_bill(2'b01);
    push_bill(2'b10);
    push_bill(2'b01);
    tick();
    check("t3_accepts", mon_acc, 4);
    check("t3_rejects", mon_rej, 1);
    check("t3_level", int'(fifo_level), 4);
    check("t3_no_pulse", pl_type.size(), 0);
    // Full FIFO: a pop on the same edge does not make room for the push.
    bus.ready = 1'b1;
    push_bill(2'b01);
    check("t3_full_pop_rej", int'(bus.bill_reject), 1);
    check("t3_full_pop_lvl", int'(fifo_level), 3);
    check("t3_full_pop_ten", int'(bus.ten), 1);
    tick();
    tick();
    // Not full: push and pop together leave the level unchanged.
    push_bill(2'b01);
    check("t3_pp_accept", int'(bus.bill_accept), 1);
    check("t3_pp_level", int'(fifo_level), 3);
    check("t3_pp_twenty", int'(bus.twenty), 1);
    bus.ready = 1'b0;
    tick();

    // Invalid codes are refused and never queued.
    do_clear();
    push_bill(2'b11);
    check("t4_rej11", int'(bus.bill_reject), 1);
    check("t4_lvl11", int'(fifo_level), 0);
    push_bill(2'b00);
    check("t4_rej00", int'(bus.bill_reject), 1);
    check("t4_acc00", int'(bus.bill_accept), 0);
    check("t4_lvl00", int'(fifo_level), 0);

    // Counter saturation and refund counting.
    do_clear();
    bus.dispense = 1'b1;
    repeat (300) tick();
    bus.dispense = 1'b0;
    check("t5_ticket_sat", int'(ticket_count), 255);
    bus.return_sig = 1'b1;
    repeat (3) tick();
    bus.return_sig = 1'b0;
    check("t5_refund", int'(refund_count), 3);

    // Clear during the first pulse wipes everything; a bill offered with clear is ignored.
    do_clear();
    bus.ready    = 1'b0;
    bus.dispense = 1'b1;
    push_bill(2'b01);
    push_bill(2'b10);
    bus.dispense = 1'b0;
    bus.ready    = 1'b1;
    tick();
    check("t6_ten", int'(bus.ten), 1);
    check("t6_ticket", int'(ticket_count), 2);
    check("t6_level", int'(fifo_level), 1);
    clear          = 1'b1;
    bus.bill_valid = 1'b1;
    bus.bill_code  = 2'b01;
    tick();
    clear          = 1'b0;
    bus.bill_valid = 1'b0;
    check("t6_clr_ten", int'(bus.ten), 0);
    check("t6_clr_twenty", int'(bus.twenty), 0);
    check("t6_clr_level", int'(fifo_level), 0);
    check("t6_clr_ticket", int'(ticket_count), 0);
    check("t6_clr_refund", int'(refund_count), 0);
    check("t6_clr_busy", int'(busy), 0);
    check("t6_clr_accept", int'(bus.bill_accept), 0);
    check("t6_clr_reject", int'(bus.bill_reject), 0);
    bus.ready = 1'b0;
    repeat (2) tick();
    check("t6_after_level", int'(fifo_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bill_feeder.md
BILL_FEEDER -- requirements
Module: bill_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, bill FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of ticket and refund counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port bill_valid  input  1  validator presents a bill this cycle.
REQ-006 SHALL have port bill_code  input  2  bill value: 2'b01 = ten, 2'b10 = twenty, 00/11 = invalid.
REQ-007 SHALL have port bill_accept  output  1  one-cycle pulse: bill stored.
REQ-008 SHALL have port bill_reject  output  1  one-cycle pulse: bill refused.
REQ-009 SHALL have port ready  input  1  ticket machine idle status.
REQ-010 SHALL have port bill  input  1  ticket machine holding partial credit.
REQ-011 SHALL have port dispense  input  1  ticket machine issuing ticket.
REQ-012 SHALL have port return_sig  input  1  ticket machine issuing refund.
REQ-013 SHALL have port ten  output  1  registered ten-unit pulse to ticket machine.
REQ-014 SHALL have port twenty  output  1  registered twenty-unit pulse to ticket machine.
REQ-015 SHALL have port ticket_count  output  CNT_W  tickets dispensed since clear.
REQ-016 SHALL have port refund_count  output  CNT_W  refunds since clear.
REQ-017 SHALL have port fifo_level  output  $clog2(DEPTH)+1  bills queued.
REQ-018 SHALL have port busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-019 SHALL, on edge with bill_valid=1, valid code and FIFO not full (level sampled before edge), write one entry (0=ten, 1=twenty) and pulse bill_accept next cycle.
REQ-020 SHALL, on bill_valid=1 with invalid code or FIFO full, discard the bill and pulse bill_reject next cycle; FIFO unchanged.
REQ-021 SHALL, when full and a pop coincides with a push, still reject the push (full judged pre-edge).
REQ-022 SHALL accept a push and pop in the same cycle when not full; fifo_level unchanged.
REQ-023 SHALL implement FSM states IDLE, PULSE, SETTLE.
REQ-024 IDLE -> PULSE when FIFO non-empty, (ready|bill)=1 and dispense=return_sig=0; pop head entry, register ten or twenty high.
REQ-025 PULSE: exactly one of ten/twenty high for exactly one cycle; -> SETTLE, both low.
REQ-026 SETTLE: ten=twenty=0 for one cycle; -> IDLE unconditionally.
REQ-027 SHALL never assert ten and twenty together; at most one pulse per 3 cycles.
REQ-028 SHALL hold in IDLE while dispense or return_sig is high or ready=bill=0.
REQ-029 Latency: bill accepted at edge N into empty FIFO, machine ready, FSM IDLE -> ten/twenty high in cycle N+1..N+2 (registered at edge N+1).
REQ-030 SHALL preserve FIFO order; pointers wrap modulo DEPTH.
REQ-031 SHALL increment ticket_count per cycle dispense=1 and refund_count per cycle return_sig=1; both saturate at all-ones.
REQ-032 fifo_level SHALL range 0..DEPTH exactly.

Reset
REQ-033 SHALL, on clear=1 at an edge, set FSM IDLE, FIFO empty, fifo_level=0, counters=0, ten=twenty=bill_accept=bill_reject=0, busy=0.
REQ-034 SHALL give clear priority over all other inputs; a bill presented with clear is neither accepted nor rejected.
REQ-035 SHALL, on clear mid-PULSE, drop ten/twenty low the following cycle; popped bill lost.

Verification
REQ-036 Ready machine, bill_valid with code 01 one cycle -> bill_accept next cycle, ten high one cycle, fifo_level 1->0.
REQ-037 Push 10,20,20 back-to-back, machine ready -> pulses ten, twenty, twenty, each 3 cycles apart; dispense seen once -> ticket_count=1.
REQ-038 DEPTH=4, machine ready=bill=0, push 5 valid bills -> 4 bill_accept, 5th bill_reject, fifo_level=4, no ten/twenty.
REQ-039 bill_code 11 and 00 with bill_valid -> bill_reject each, fifo_level stays 0.
REQ-040 Hold dispense=1 for 300 cycles -> ticket_count saturates at 255.
REQ-041 Queue 2 bills, clear asserted during first PULSE -> next cycle ten=twenty=0, fifo_level=0, counters 0, busy=0.
